// File: rtl/mx_pe_acc_if.sv
`default_nettype none
// ============================================================================
// Module : mx_pe_acc_if
// Brief  : Beat, forward and result signals of one mx_pe_acc processing element
// Rev    : 1.0
// ============================================================================
interface mx_pe_acc_if #(
    parameter int DW  = 16,
    parameter int SEW = 5,
    parameter int OW  = 16
);
    logic           IN_VALID;
    logic [DW-1:0]  W_IN;
    logic [DW-1:0]  D_IN;
    logic [SEW-1:0] W_SE;
    logic [SEW-1:0] D_SE;
    logic [1:0]     OP;
    logic           ACC_CLR;
    logic [DW-1:0]  W_OUT;
    logic [DW-1:0]  D_OUT;
    logic           OUT_VALID;
    logic [OW-1:0]  RESULT;
    logic           RESULT_VALID;
    logic           SAT;

    modport master (
        output IN_VALID, W_IN, D_IN, W_SE, D_SE, OP, ACC_CLR,
        input  W_OUT, D_OUT, OUT_VALID, RESULT, RESULT_VALID, SAT
    );

    modport slave (
        input  IN_VALID, W_IN, D_IN, W_SE, D_SE, OP, ACC_CLR,
        output W_OUT, D_OUT, OUT_VALID, RESULT, RESULT_VALID, SAT
    );
endinterface
`default_nettype wire

// File: rtl/mx_pe_acc.sv
`default_nettype none
// ============================================================================
// Module : mx_pe_acc
// Brief  : MXINT systolic PE: align, mul/add/sub/MAC, saturate; 1-cycle forward
// Rev    : 1.0
// ============================================================================
module mx_pe_acc #(
    parameter int DW          = 16,
    parameter int SEW         = 5,
    parameter int AW          = 20,
    parameter int SA          = 6,
    parameter int FIXED_POINT = 8,
    parameter int ACCW        = 40,
    parameter int OW          = 16
) (
    input  wire logic   CLK,
    input  wire logic   RST,
    mx_pe_acc_if.slave  bus
);

    localparam logic [1:0] C_OP_MUL = 2'b00;
    localparam logic [1:0] C_OP_ADD = 2'b01;
    localparam logic [1:0] C_OP_SUB = 2'b10;
    localparam logic [1:0] C_OP_MAC = 2'b11;

    localparam logic signed [ACCW-1:0] C_MAX = ACCW'((64'sd1 <<< (OW-1)) - 64'sd1);
    localparam logic signed [ACCW-1:0] C_MIN = ~C_MAX;

    // Stage 1: neighbour forwarding and operand alignment
    logic [DW-1:0]          w_out_q, d_out_q;
    logic                   out_valid_q;
    logic signed [AW-1:0]   w_w_ext, w_d_ext, w_wa, w_da;
    logic signed [AW-1:0]   wa1_q, da1_q;
    logic [1:0]             op1_q;
    logic                   clr1_q, v1_q;

    assign w_w_ext = AW'($signed(bus.W_IN));
    assign w_d_ext = AW'($signed(bus.D_IN));
    assign w_wa    = w_w_ext <<< bus.W_SE;
    assign w_da    = w_d_ext <<< bus.D_SE;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            w_out_q     <= '0;
            d_out_q     <= '0;
            out_valid_q <= 1'b0;
            wa1_q       <= '0;
            da1_q       <= '0;
            op1_q       <= '0;
            clr1_q      <= 1'b0;
            v1_q        <= 1'b0;
        end else begin
            w_out_q     <= bus.W_IN;
            d_out_q     <= bus.D_IN;
            out_valid_q <= bus.IN_VALID;
            wa1_q       <= w_wa;
            da1_q       <= w_da;
            op1_q       <= bus.OP;
            clr1_q      <= bus.ACC_CLR;
            v1_q        <= bus.IN_VALID;
        end
    end

    // Stage 2: arithmetic at ACCW, scale removed by arithmetic right shifts
    logic signed [ACCW-1:0] w_wx, w_dx, w_prod, w_mul, w_add, w_sub, w_acc_base, w_mac;
    logic signed [ACCW-1:0] acc_q, acc_d, res2_q, res2_d;
    logic                   v2_q;

    assign w_wx       = ACCW'(wa1_q);
    assign w_dx       = ACCW'(da1_q);
    assign w_prod     = w_wx * w_dx;
    assign w_mul      = w_prod >>> (2*SA + FIXED_POINT);
    assign w_add      = (w_wx + w_dx) >>> SA;
    assign w_sub      = (w_dx - w_wx) >>> SA;
    assign w_acc_base = clr1_q ? '0 : acc_q;
    assign w_mac      = w_acc_base + w_mul;

    always_comb begin
        acc_d  = acc_q;
        res2_d = res2_q;
        if (v1_q) begin
            case (op1_q)
                C_OP_MUL: res2_d = w_mul;
                C_OP_ADD: res2_d = w_add;
                C_OP_SUB: res2_d = w_sub;
                default: begin
                    acc_d  = w_mac;
                    res2_d = w_mac;
                end
            endcase
            if (clr1_q && (op1_q != C_OP_MAC)) begin
                acc_d = '0;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            acc_q  <= '0;
            res2_q <= '0;
            v2_q   <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            res2_q <= res2_d;
            v2_q   <= v1_q;
        end
    end

    // Stage 3: clamp to the OW-bit signed range
    logic [OW-1:0] result_q;
    logic          result_valid_q, sat_q;
    logic          w_hi, w_lo;

    assign w_hi = res2_q > C_MAX;
    assign w_lo = res2_q < C_MIN;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            result_q       <= '0;
            sat_q          <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            result_valid_q <= v2_q;
            if (v2_q) begin
                result_q <= w_hi ? C_MAX[OW-1:0] : (w_lo ? C_MIN[OW-1:0] : res2_q[OW-1:0]);
                sat_q    <= w_hi | w_lo;
            end
        end
    end

    assign bus.W_OUT        = w_out_q;
    assign bus.D_OUT        = d_out_q;
    assign bus.OUT_VALID    = out_valid_q;
    assign bus.RESULT       = result_q;
    assign bus.RESULT_VALID = result_valid_q;
    assign bus.SAT          = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_mx_pe_acc.sv
`default_nettype none
// ============================================================================
// Module : tb_mx_pe_acc
// Brief  : Scoreboard bench for mx_pe_acc at default and narrow parameter sets
// Rev    : 1.0
// ============================================================================
module tb_mx_pe_acc;
    localparam int SEW = 5;
    localparam int A_DW = 16, A_AW = 20, A_SA = 6, A_FP = 8, A_ACCW = 40, A_OW = 16;
    localparam int B_DW = 8,  B_AW = 12, B_SA = 3, B_FP = 4, B_ACCW = 24, B_OW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mx_pe_acc_if #(.DW(A_DW), .SEW(SEW), .OW(A_OW)) bus_a ();
    mx_pe_acc_if #(.DW(B_DW), .SEW(SEW), .OW(B_OW)) bus_b ();

    mx_pe_acc #(.DW(A_DW), .SEW(SEW), .AW(A_AW), .SA(A_SA), .FIXED_POINT(A_FP),
                .ACCW(A_ACCW), .OW(A_OW)) u_dut_a (.CLK(clk), .RST(rst), .bus(bus_a));
    mx_pe_acc #(.DW(B_DW), .SEW(SEW), .AW(B_AW), .SA(B_SA), .FIXED_POINT(B_FP),
                .ACCW(B_ACCW), .OW(B_OW)) u_dut_b (.CLK(clk), .RST(rst), .bus(bus_b));

    typedef struct { longint res; longint sat; int due; } exp_t;
    exp_t   q_a[$], q_b[$];
    int     errors = 0, checks = 0, cyc = 0;
    longint acc_a = 0, acc_b = 0, last_a = 0, lsat_a = 0, last_b = 0, lsat_b = 0;
    logic [A_DW-1:0] fa_w, fa_d;
    logic [B_DW-1:0] fb_w, fb_d;
    logic            fa_v, fb_v;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Sign-interpret the low n bits of x
    function automatic longint wrapn(input longint x, input int n);
        return (x <<< (64 - n)) >>> (64 - n);
    endfunction

    task automatic model(inout longint acc, input int w, d, wse, dse, op, clr,
                         input int dw, aw, sa, fp, accw, ow,
                         output longint er, output longint es);
        longint wa, da, mul, r, mx, mn;
        wa  = wrapn(wrapn(longint'(w), dw) <<< wse, aw);
        da  = wrapn(wrapn(longint'(d), dw) <<< dse, aw);
        mul = wrapn(wa * da, accw) >>> (2*sa + fp);
        case (op)
            0: r = mul;
            1: r = (wa + da) >>> sa;
            2: r = (da - wa) >>> sa;
            default: begin
                acc = wrapn((clr != 0 ? 64'sd0 : acc) + mul, accw);
                r   = acc;
            end
        endcase
        if (clr != 0 && op != 3) acc = 0;
        mx = (longint'(1) <<< (ow - 1)) - 1;
        mn = -mx - 1;
        er = (r > mx) ? mx : ((r < mn) ? mn : r);
        es = (r > mx || r < mn) ? 1 : 0;
    endtask

    task automatic drive_a(input bit v, input int w, d, wse, dse, op, clr,
                           input bit ux = 0, input longint xr = 0, input longint xs = 0);
        longint er, es;
        bus_a.IN_VALID = v;
        bus_a.W_IN     = A_DW'(w);
        bus_a.D_IN     = A_DW'(d);
        bus_a.W_SE     = SEW'(wse);
        bus_a.D_SE     = SEW'(dse);
        bus_a.OP       = 2'(op);
        bus_a.ACC_CLR  = clr[0];
        if (v) begin
            model(acc_a, w, d, wse, dse, op, clr, A_DW, A_AW, A_SA, A_FP, A_ACCW, A_OW, er, es);
            if (ux) begin er = xr; es = xs; end
            q_a.push_back('{er, es, cyc + 3});
        end
    endtask

    task automatic drive_b(input bit v, input int w, d, wse, dse, op, clr,
                           input bit ux = 0, input longint xr = 0, input longint xs = 0);
        longint er, es;
        bus_b.IN_VALID = v;
        bus_b.W_IN     = B_DW'(w);
        bus_b.D_IN     = B_DW'(d);
        bus_b.W_SE     = SEW'(wse);
        bus_b.D_SE     = SEW'(dse);
        bus_b.OP       = 2'(op);
        bus_b.ACC_CLR  = clr[0];
        if (v) begin
            model(acc_b, w, d, wse, dse, op, clr, B_DW, B_AW, B_SA, B_FP, B_ACCW, B_OW, er, es);
            if (ux) begin er = xr; es = xs; end
            q_b.push_back('{er, es, cyc + 3});
        end
    endtask

    task automatic idle(input int n);
        drive_a(0, 0, 0, 0, 0, 0, 0);
        drive_b(0, 0, 0, 0, 0, 0, 0);
        repeat (n) @(negedge clk);
    endtask

    // Forwarding reference: previous edge's inputs
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            fa_w = '0; fa_d = '0; fa_v = 1'b0;
            fb_w = '0; fb_d = '0; fb_v = 1'b0;
        end else begin
            fa_w = bus_a.W_IN; fa_d = bus_a.D_IN; fa_v = bus_a.IN_VALID;
            fb_w = bus_b.W_IN; fb_d = bus_b.D_IN; fb_v = bus_b.IN_VALID;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (bus_a.RESULT_VALID) begin
            if (q_a.size() == 0) begin
                checks++; errors++;
                $display("FAIL a_unexpected: got result %0d expected no result", $signed(bus_a.RESULT));
            end else begin
                e = q_a.pop_front();
                chk("a_result", longint'($signed(bus_a.RESULT)), e.res);
                chk("a_sat", longint'(bus_a.SAT), e.sat);
                chk("a_latency", cyc, e.due);
                last_a = e.res; lsat_a = e.sat;
            end
        end else begin
            chk("a_hold", longint'($signed(bus_a.RESULT)), last_a);
            chk("a_sat_hold", longint'(bus_a.SAT), lsat_a);
        end
        if (q_a.size() > 0 && q_a[0].due < cyc) begin
            chk("a_missing", cyc, q_a[0].due);
            void'(q_a.pop_front());
        end
        chk("a_w_out", longint'(bus_a.W_OUT), longint'(fa_w));
        chk("a_d_out", longint'(bus_a.D_OUT), longint'(fa_d));
        chk("a_out_valid", longint'(bus_a.OUT_VALID), longint'(fa_v));
    end

    always @(negedge clk) begin
        exp_t e;
        if (bus_b.RESULT_VALID) begin
            if (q_b.size() == 0) begin
                checks++; errors++;
                $display("FAIL b_unexpected: got result %0d expected no result", $signed(bus_b.RESULT));
            end else begin
                e = q_b.pop_front();
                chk("b_result", longint'($signed(bus_b.RESULT)), e.res);
                chk("b_sat", longint'(bus_b.SAT), e.sat);
                chk("b_latency", cyc, e.due);
                last_b = e.res; lsat_b = e.sat;
            end
        end else begin
            chk("b_hold", longint'($signed(bus_b.RESULT)), last_b);
            chk("b_sat_hold", longint'(bus_b.SAT), lsat_b);
        end
        if (q_b.size() > 0 && q_b[0].due < cyc) begin
            chk("b_missing", cyc, q_b[0].due);
            void'(q_b.pop_front());
        end
        chk("b_w_out", longint'(bus_b.W_OUT), longint'(fb_w));
        chk("b_d_out", longint'(bus_b.D_OUT), longint'(fb_d));
        chk("b_out_valid", longint'(bus_b.OUT_VALID), longint'(fb_v));
    end

    initial begin
        idle(0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_result", longint'(bus_a.RESULT), 0);
        chk("reset_rv", longint'(bus_a.RESULT_VALID), 0);

        // mul, then add/sub back-to-back, then saturation both directions
        drive_a(1, 'h0100, 'h0200, 6, 6, 0, 0, 1, 512, 0);
        @(negedge clk);
        chk("fw_w_after_mul", longint'(bus_a.W_OUT), 'h0100);
        chk("fw_d_after_mul", longint'(bus_a.D_OUT), 'h0200);
        drive_a(1, 'h0100, 'h0080, 6, 6, 1, 0, 1, 384, 0);  @(negedge clk);
        drive_a(1, 'h0100, 'h0080, 6, 6, 2, 0, 1, -128, 0); @(negedge clk);
        drive_a(1, 'h7FFF, 'h7FFF, 4, 4, 0, 0, 1, 32767, 1); @(negedge clk);
        drive_a(1, 'h8001, 'h7FFF, 4, 4, 0, 0, 1, -32768, 1); @(negedge clk);
        idle(4);

        // MAC without and with a 2-cycle gap
        for (int i = 0; i < 4; i++) begin
            drive_a(1, 'h0100, 'h0100, 6, 6, 3, (i == 0) ? 1 : 0, 1, 256 * (i + 1), 0);
            @(negedge clk);
        end
        for (int i = 0; i < 4; i++) begin
            if (i == 2) idle(2);
            drive_a(1, 'h0100, 'h0100, 6, 6, 3, (i == 0) ? 1 : 0, 1, 256 * (i + 1), 0);
            @(negedge clk);
        end
        idle(1);

        // narrow parameter set: mul and MAC
        drive_b(1, 'h10, 'h20, 3, 3, 0, 0, 1, 32, 0); @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            drive_b(1, 'h10, 'h10, 3, 3, 3, (i == 0) ? 1 : 0, 1, 16 * (i + 1), 0);
            @(negedge clk);
        end
        idle(5);

        // asynchronous reset with MAC beats in flight
        for (int i = 0; i < 3; i++) begin
            drive_a(1, 'h0100, 'h0100, 6, 6, 3, 0);
            drive_b(1, 'h10, 'h10, 3, 3, 3, 0);
            @(negedge clk);
        end
        idle(0);
        #2;
        rst = 1'b1;
        q_a.delete(); q_b.delete();
        acc_a = 0; acc_b = 0; last_a = 0; lsat_a = 0; last_b = 0; lsat_b = 0;
        #1;
        chk("async_rst_result", longint'(bus_a.RESULT), 0);
        chk("async_rst_rv", longint'(bus_a.RESULT_VALID), 0);
        chk("async_rst_sat", longint'(bus_a.SAT), 0);
        chk("async_rst_w_out", longint'(bus_a.W_OUT), 0);
        chk("async_rst_d_out", longint'(bus_a.D_OUT), 0);
        chk("async_rst_out_valid", longint'(bus_a.OUT_VALID), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rv_after_release", longint'(bus_a.RESULT_VALID), 0);
        end
        drive_a(1, 'h0100, 'h0100, 6, 6, 3, 0, 1, 256, 0);
        drive_b(1, 'h10, 'h10, 3, 3, 3, 0, 1, 16, 0);
        @(negedge clk);

        // randomized mixed streams on both instances
        for (int n = 0; n < 600; n++) begin
            int sa_w, sa_d;
            sa_w = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 9);
            sa_d = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 9);
            drive_a($urandom_range(0, 3) != 0, int'($urandom_range(0, 'hFFFF)),
                    int'($urandom_range(0, 'hFFFF)), sa_w, sa_d,
                    $urandom_range(0, 3), ($urandom_range(0, 7) == 0) ? 1 : 0);
            drive_b($urandom_range(0, 3) != 0, int'($urandom_range(0, 'hFF)),
                    int'($urandom_range(0, 'hFF)), $urandom_range(0, 6), $urandom_range(0, 6),
                    $urandom_range(0, 3), ($urandom_range(0, 7) == 0) ? 1 : 0);
            @(negedge clk);
        end
        idle(0);
        for (int i = 0; i < 20 && (q_a.size() + q_b.size()) > 0; i++) @(negedge clk);
        chk("a_drain", q_a.size(), 0);
        chk("b_drain", q_b.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
